// File: rtl/pcie_cfg_mgmt_responder_if.sv
// cfg_mgmt port bundle between the configuration initiator (master)
// and the responder (slave).
interface pcie_cfg_mgmt_responder_if;
    logic [9:0]  cfg_mgmt_addr;
    logic [7:0]  cfg_mgmt_function_number;
    logic        cfg_mgmt_write;
    logic [31:0] cfg_mgmt_write_data;
    logic [3:0]  cfg_mgmt_byte_enable;
    logic        cfg_mgmt_read;
    logic [31:0] cfg_mgmt_read_data;
    logic        cfg_mgmt_read_write_done;
    logic        cfg_mgmt_err;

    modport master (
        output cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
               cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read,
        input  cfg_mgmt_read_data, cfg_mgmt_read_write_done, cfg_mgmt_err
    );

    modport slave (
        input  cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
               cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read,
        output cfg_mgmt_read_data, cfg_mgmt_read_write_done, cfg_mgmt_err
    );
endinterface

// File: rtl/pcie_cfg_mgmt_responder.sv
// Emulated PCIe hard-IP cfg_mgmt responder with a per-function config register file.
// Optional macro CFG_MGMT_RESP_ERR_EN drives cfg_mgmt_err on illegal accesses.
module pcie_cfg_mgmt_responder #(
    parameter int unsigned FUNC_COUNT    = 1,
    parameter int unsigned MEM_DW_LOG2   = 6,
    parameter int unsigned LATENCY       = 2,
    parameter logic [15:0] VENDOR_ID     = 16'h1234,
    parameter logic [15:0] DEVICE_ID     = 16'h0001,
    parameter logic [7:0]  PCIE_CAP_DW   = 8'h1C,
    parameter logic [2:0]  MPS_SUPPORTED = 3'd2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pcie_cfg_mgmt_responder_if.slave    cfg,
    output logic [2:0]                  cfg_max_payload,
    output logic [2:0]                  cfg_max_read_req
);

    localparam int          DEPTH      = 1 << MEM_DW_LOG2;
    localparam int          AW         = MEM_DW_LOG2;
    localparam int          FW         = (FUNC_COUNT > 1) ? $clog2(FUNC_COUNT) : 1;
    localparam logic [10:0] DEPTH_L    = 11'(DEPTH);
    localparam logic [8:0]  FUNC_L     = 9'(FUNC_COUNT);
    localparam int          DEVCTL_I   = int'(PCIE_CAP_DW) + 2;
    localparam bit          DEVCTL_OK  = DEVCTL_I < DEPTH;
    localparam logic [AW-1:0] DEVCTL_A = AW'(DEVCTL_I);
    localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            load, commit, req, illegal_in;
    logic [AW-1:0]   addr_q;
    logic [FW-1:0]   func_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic            wr_q, rd_q, illegal_q;
    logic [31:0]     mem [FUNC_COUNT][DEPTH];
    logic [31:0]     cur_word, wr_word;

    function automatic logic [31:0] rst_word(input int a);
        if (a == 0)
            return {DEVICE_ID, VENDOR_ID};
        else if (DEVCTL_OK && a == DEVCTL_I)
            return 32'h0000_2000;
        else
            return 32'h0;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++)
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        return res;
    endfunction

    // Payload size can never exceed what the emulated core advertises.
    function automatic logic [2:0] clamp_mps(input logic [2:0] mps);
        return (mps > MPS_SUPPORTED) ? MPS_SUPPORTED : mps;
    endfunction

    assign req        = cfg.cfg_mgmt_read | cfg.cfg_mgmt_write;
    assign illegal_in = ({1'b0, cfg.cfg_mgmt_function_number} >= FUNC_L) ||
                        ({1'b0, cfg.cfg_mgmt_addr} >= DEPTH_L) ||
                        (cfg.cfg_mgmt_read & cfg.cfg_mgmt_write);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                load    = 1'b1;
                cnt_d   = LAT_M1;
                state_d = (LATENCY == 1) ? DONE : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                commit  = wr_q & ~illegal_q & (addr_q != '0);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            func_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else if (load) begin
            addr_q    <= cfg.cfg_mgmt_addr[AW-1:0];
            func_q    <= cfg.cfg_mgmt_function_number[FW-1:0];
            wdata_q   <= cfg.cfg_mgmt_write_data;
            be_q      <= cfg.cfg_mgmt_byte_enable;
            wr_q      <= cfg.cfg_mgmt_write;
            rd_q      <= cfg.cfg_mgmt_read;
            illegal_q <= illegal_in;
        end
    end

    assign cur_word = mem[func_q][addr_q];

    always_comb begin
        wr_word = merge_bytes(cur_word, wdata_q, be_q);
        if (DEVCTL_OK && addr_q == DEVCTL_A) wr_word[31:16] = 16'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < int'(FUNC_COUNT); f++)
                for (int a = 0; a < DEPTH; a++)
                    mem[FW'(f)][AW'(a)] <= rst_word(a);
        end else if (commit) begin
            mem[func_q][addr_q] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_max_payload  <= 3'd0;
            cfg_max_read_req <= 3'd2;
        end else begin
            cfg_max_payload  <= clamp_mps(mem[FW'(0)][DEVCTL_A][7:5]);
            cfg_max_read_req <= mem[FW'(0)][DEVCTL_A][14:12];
        end
    end

    assign cfg.cfg_mgmt_read_write_done = (state_q == DONE);
    assign cfg.cfg_mgmt_read_data = ((state_q == DONE) && rd_q && !illegal_q) ? cur_word : 32'h0;

`ifdef CFG_MGMT_RESP_ERR_EN
    assign cfg.cfg_mgmt_err = (state_q == DONE) & illegal_q;
`else
    assign cfg.cfg_mgmt_err = 1'b0;
`endif

endmodule

// File: tb/tb_pcie_cfg_mgmt_responder.sv
// Randomized bench for pcie_cfg_mgmt_responder against a dword-map reference model.
module tb_pcie_cfg_mgmt_responder;
    localparam int LAT    = 2;
    localparam int NFUNC  = 1;
    localparam int DEPTH  = 64;
    localparam int DEVCTL = 'h1E;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] max_pl, max_rr;
    int         checks = 0;
    int         errors = 0;
    logic [31:0] model_mem [int];

    always #5 clk = ~clk;

    pcie_cfg_mgmt_responder_if bus ();

    pcie_cfg_mgmt_responder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg              (bus.slave),
        .cfg_max_payload  (max_pl),
        .cfg_max_read_req (max_rr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_mem.delete();
        for (int a = 0; a < NFUNC * DEPTH; a++) model_mem[a] = 32'h0;
        for (int f = 0; f < NFUNC; f++) begin
            model_mem[f * DEPTH]          = 32'h0001_1234;
            model_mem[f * DEPTH + DEVCTL] = 32'h0000_2000;
        end
    endtask

    task automatic bus_idle();
        bus.cfg_mgmt_addr            = '0;
        bus.cfg_mgmt_function_number = '0;
        bus.cfg_mgmt_write           = 1'b0;
        bus.cfg_mgmt_write_data      = '0;
        bus.cfg_mgmt_byte_enable     = '0;
        bus.cfg_mgmt_read            = 1'b0;
    endtask

    task automatic check_max(input string tag);
        logic [31:0] dv;
        logic [2:0]  mps;
        dv  = model_mem[DEVCTL];
        mps = dv[7:5];
        check_eq({tag, "_mps"}, {29'h0, max_pl}, (mps > 3'd2) ? 32'd2 : {29'h0, mps});
        check_eq({tag, "_mrrs"}, {29'h0, max_rr}, {29'h0, dv[14:12]});
    endtask

    // Called one time unit after a rising edge; returns likewise, one cycle after done.
    task automatic run_txn(input string tag, input logic [7:0] f, input logic [9:0] a,
                           input logic rd, input logic wr, input logic [31:0] d,
                           input logic [3:0] be);
        int          k;
        bit          seen, ill;
        logic [31:0] exp_data, nw;
        int          idx;
        bus.cfg_mgmt_addr            = a;
        bus.cfg_mgmt_function_number = f;
        bus.cfg_mgmt_read            = rd;
        bus.cfg_mgmt_write           = wr;
        bus.cfg_mgmt_write_data      = d;
        bus.cfg_mgmt_byte_enable     = be;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (bus.cfg_mgmt_read_write_done) seen = 1'b1;
        end
        bus.cfg_mgmt_read  = 1'b0;
        bus.cfg_mgmt_write = 1'b0;
        if (!seen) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        ill = (int'(f) >= NFUNC) || (int'(a) >= DEPTH) || (rd && wr);
        idx = int'(f) * DEPTH + int'(a);
        exp_data = (rd && !ill) ? model_mem[idx] : 32'h0;
        check_eq({tag, "_lat"}, k, LAT);
        if (rd || ill) check_eq({tag, "_data"}, bus.cfg_mgmt_read_data, exp_data);
`ifdef CFG_MGMT_RESP_ERR_EN
        check_eq({tag, "_err"}, {31'h0, bus.cfg_mgmt_err}, {31'h0, ill});
`else
        check_eq({tag, "_err"}, {31'h0, bus.cfg_mgmt_err}, 32'h0);
`endif
        if (wr && !ill && a != 10'd0) begin
            nw = model_mem[idx];
            for (int i = 0; i < 4; i++)
                if (be[i]) nw[8*i +: 8] = d[8*i +: 8];
            if (int'(a) == DEVCTL) nw[31:16] = 16'h0;
            model_mem[idx] = nw;
        end
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, {31'h0, bus.cfg_mgmt_read_write_done}, 32'h0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        bus_idle();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_done", {31'h0, bus.cfg_mgmt_read_write_done}, 32'h0);
        check_eq("rst_err", {31'h0, bus.cfg_mgmt_err}, 32'h0);
        check_eq("rst_rdata", bus.cfg_mgmt_read_data, 32'h0);
        check_max("rst");
        rst_n = 1'b1;
        idle_cycles(1);

        run_txn("id_read", 8'd0, 10'd0, 1'b1, 1'b0, 32'h0, 4'h0);

        run_txn("devctl_wr", 8'd0, 10'h1E, 1'b0, 1'b1, 32'hFFFF_50A0, 4'hF);
        idle_cycles(1);
        check_max("devctl");
        check_eq("devctl_mps_lit", {29'h0, max_pl}, 32'd2);
        check_eq("devctl_mrrs_lit", {29'h0, max_rr}, 32'd5);
        run_txn("devctl_rd", 8'd0, 10'h1E, 1'b1, 1'b0, 32'h0, 4'h0);

        run_txn("be_wr", 8'd0, 10'h05, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0101);
        run_txn("be_rd", 8'd0, 10'h05, 1'b1, 1'b0, 32'h0, 4'h0);
        check_eq("be_lit", model_mem[5], 32'h00BB_00DD);

        run_txn("oor_rd", 8'd0, 10'h40, 1'b1, 1'b0, 32'h0, 4'h0);
        run_txn("func1_rd", 8'd1, 10'h00, 1'b1, 1'b0, 32'h0, 4'h0);
        run_txn("oor_wr", 8'd0, 10'h45, 1'b0, 1'b1, 32'h1111_1111, 4'hF);
        run_txn("func1_wr", 8'd1, 10'h05, 1'b0, 1'b1, 32'h2222_2222, 4'hF);
        run_txn("noharm_rd", 8'd0, 10'h05, 1'b1, 1'b0, 32'h0, 4'h0);

        run_txn("ro_wr", 8'd0, 10'h00, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF);
        run_txn("ro_rd", 8'd0, 10'h00, 1'b1, 1'b0, 32'h0, 4'h0);
        run_txn("both", 8'd0, 10'h05, 1'b1, 1'b1, 32'h0, 4'hF);
        run_txn("both_rd", 8'd0, 10'h05, 1'b1, 1'b0, 32'h0, 4'h0);

        // Reset asserted while the responder is counting down.
        bus.cfg_mgmt_addr = 10'h1E;
        bus.cfg_mgmt_read = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus_idle();
        #1;
        check_eq("midrst_mrrs", {29'h0, max_rr}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("midrst_done", {31'h0, bus.cfg_mgmt_read_write_done}, 32'h0);
        end
        rst_n = 1'b1;
        model_reset();
        idle_cycles(2);
        check_eq("postrst_done", {31'h0, bus.cfg_mgmt_read_write_done}, 32'h0);
        check_max("postrst");
        run_txn("postrst_rd", 8'd0, 10'h1E, 1'b1, 1'b0, 32'h0, 4'h0);

        for (int n = 0; n < 300; n++) begin
            int          sel, op, gap;
            logic [9:0]  a;
            logic [7:0]  f;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 10'd0;
            else if (sel < 3)  a = 10'h1E;
            else if (sel == 3) a = 10'($urandom_range(64, 1023));
            else               a = 10'($urandom_range(0, 63));
            f  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            op = $urandom_range(0, 9);
            run_txn("rand", f, a, (op < 4) || (op == 9), op >= 4, $urandom, 4'($urandom_range(0, 15)));
            gap = $urandom_range(0, 2);
            idle_cycles(gap);
            if (gap >= 1) check_max("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
